// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO; divide datapath present only when MDU_DIV_EN is defined
module mult_div_unit #(
  parameter int num_bit = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [num_bit-1:0] data1,
  input  logic [num_bit-1:0] data2,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [num_bit-1:0] hi,
  output logic [num_bit-1:0] lo
);
  localparam int W  = num_bit;
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;
  state_t r_state, w_next;

  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_opnd;   // multiplicand (mult) or divisor (div) magnitude
  logic [2*W-1:0] r_acc;    // product; low half starts as multiplier, or holds dividend -> quotient
  logic           r_neg_q;  // negate product/quotient in FIX
  logic           r_done;
  logic [W-1:0]   r_hi, r_lo;

  logic           w_signed, w_accept;
  logic [W-1:0]   w_mag1, w_mag2;
  logic [W:0]     w_sum;
  logic [2*W-1:0] w_prod;

`ifdef MDU_DIV_EN
  logic           r_is_div;
  logic           r_neg_r;  // remainder follows dividend sign
  logic [W-1:0]   r_rem;
  logic [W:0]     w_trial;  // 33-bit partial remainder after shifting in next dividend bit
  logic           w_ge;
  logic [W-1:0]   w_diff, w_quo, w_remf;

  assign w_accept = start & ~abort;
`else
  assign w_accept = start & ~abort & ~op[1];
`endif

  assign w_signed = ~op[0];
  assign w_mag1   = (w_signed & data1[W-1]) ? -data1 : data1;
  assign w_mag2   = (w_signed & data2[W-1]) ? -data2 : data2;

  // shift-add step: add multiplicand into upper half when current multiplier bit is set
  assign w_sum  = {1'b0, r_acc[2*W-1:W]} + {1'b0, (r_acc[0] ? r_opnd : {W{1'b0}})};
  assign w_prod = r_neg_q ? -r_acc : r_acc;

`ifdef MDU_DIV_EN
  // restoring step: subtract only when the trial remainder covers the divisor
  assign w_trial = {r_rem, r_acc[W-1]};
  assign w_ge    = (w_trial >= {1'b0, r_opnd});
  assign w_diff  = w_trial[W-1:0] - r_opnd;
  assign w_quo   = r_neg_q ? -r_acc[W-1:0] : r_acc[W-1:0];
  assign w_remf  = r_neg_r ? -r_rem : r_rem;
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // next-state logic; abort returns to IDLE from any busy state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (abort) w_next = S_IDLE;
               else if (r_cnt == LAST) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // operand capture, iteration datapath and HI/LO write-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_opnd  <= '0;
      r_acc   <= '0;
      r_neg_q <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
`ifdef MDU_DIV_EN
      r_is_div <= 1'b0;
      r_neg_r  <= 1'b0;
      r_rem    <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_cnt <= '0;
          // a zero divisor must leave the all-ones quotient unnegated
          r_neg_q <= w_signed & (data1[W-1] ^ data2[W-1]) & (|data2);
`ifdef MDU_DIV_EN
          r_is_div <= op[1];
          r_neg_r  <= w_signed & data1[W-1];
          r_rem    <= '0;
          if (op[1]) begin
            r_opnd <= w_mag2;
            r_acc  <= {{W{1'b0}}, w_mag1};
          end else begin
            r_opnd <= w_mag1;
            r_acc  <= {{W{1'b0}}, w_mag2};
          end
`else
          r_opnd <= w_mag1;
          r_acc  <= {{W{1'b0}}, w_mag2};
`endif
        end
        S_RUN: if (!abort) begin
          r_cnt <= r_cnt + 1'b1;
`ifdef MDU_DIV_EN
          if (r_is_div) begin
            r_rem        <= w_ge ? w_diff : w_trial[W-1:0];
            r_acc[W-1:0] <= {r_acc[W-2:0], w_ge};
          end else begin
            r_acc <= {w_sum, r_acc[W-1:1]};
          end
`else
          r_acc <= {w_sum, r_acc[W-1:1]};
`endif
        end
        S_FIX: if (!abort) begin
          r_done <= 1'b1;
`ifdef MDU_DIV_EN
          if (r_is_div) begin
            r_hi <= w_remf;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod[2*W-1:W];
            r_lo <= w_prod[W-1:0];
          end
`else
          r_hi <= w_prod[2*W-1:W];
          r_lo <= w_prod[W-1:0];
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit with random ops and a plain-arithmetic reference model
module tb_mult_div_unit;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] data1 = '0;
  logic [31:0] data2 = '0;
  logic        abort = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          e0;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        prev_done = 1'b0;

  mult_div_unit #(.num_bit(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .data1(data1), .data2(data2),
    .abort(abort), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  // Reference: MIPS semantics from plain integer arithmetic.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint pa, pb;
    int sa, sb;
    case (o)
      2'b00: begin
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return pa * pb;
      end
      2'b01: return {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o == 2'b10) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
          sa = a;
          sb = b;
          return {32'(sa % sb), 32'(sa / sb)};
        end
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return $urandom();
      1: return $urandom_range(0, 20);
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF - $urandom_range(0, 3);
      default: return $urandom() & 32'hFF00_00FF;
    endcase
  endfunction

  // Must be called at a negedge; returns #1 after the sampling edge E0 (accepted) or at a negedge (ignored).
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic acc;
    logic [63:0] r;
    exp_t e;
    acc = !o[1] || DIV_EN;
    op = o; data1 = a; data2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'(acc));
    if (acc) begin
      r = ref_model(o, a, b);
      e.hi = r[63:32]; e.lo = r[31:0]; e.e0 = cyc;
      exp_q.push_back(e);
      m_hi = e.hi; m_lo = e.lo;
    end else begin
      repeat (2) @(negedge clk);
      check("ignored_busy", 64'(busy), 64'd0);
      check("ignored_hi", 64'(hi), 64'(m_hi));
      check("ignored_lo", 64'(lo), 64'(m_lo));
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 200);
    check("idle_timeout", 64'(busy), 64'd0);
  endtask

  // Monitor: pop expected result on every done pulse
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (done) begin
        check("done_one_cycle", 64'(prev_done), 64'd0);
        check("done_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_hi", 64'(hi), 64'(e.hi));
          check("sb_lo", 64'(lo), 64'(e.lo));
          check("sb_latency", 64'(cyc - e.e0), 64'd33);
        end
      end
      prev_done = done;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sv_hi, sv_lo;
    int nb;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // MULT -1 x 7 with busy-length measurement
    issue(2'b00, 32'hFFFF_FFFF, 32'd7);
    nb = 0;
    while (nb < 200) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
    end
    check("busy_cycles", 64'(nb), 64'd33);
    check("done_after_E33", 64'(done), 64'd1);
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo), 64'hFFFF_FFF9);

    // MULTU max x max, then back-to-back MULTU 3x5 in the done cycle
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle();
    check("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    check("multu_lo", 64'(lo), 64'h1);
    issue(2'b01, 32'd3, 32'd5);
    wait_idle();
    check("b2b_hi", 64'(hi), 64'd0);
    check("b2b_lo", 64'(lo), 64'd15);

    // Divide cases (ignored entirely when the divider is not built)
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    issue(2'b11, 32'd100, 32'd7);
    wait_idle();
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    issue(2'b11, 32'd5, 32'd0);
    wait_idle();
`ifdef MDU_DIV_EN
    check("divu0_hi", 64'(hi), 64'd5);
    check("divu0_lo", 64'(lo), 64'hFFFF_FFFF);
`endif
    issue(2'b10, 32'hFFFF_FFFB, 32'd0);
    wait_idle();

    // Random operations
    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(0, 3)), pick(), pick());
      wait_idle();
    end

    // Ignored start at iteration 5, abort at iteration 10
    sv_hi = m_hi; sv_lo = m_lo;
    issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (5) @(negedge clk);
    op = 2'b01; data1 = 32'd1; data2 = 32'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_during_stray_start", 64'(busy), 64'd1);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    void'(exp_q.pop_back());
    m_hi = sv_hi; m_lo = sv_lo;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hi", 64'(hi), 64'(sv_hi));
    check("abort_lo", 64'(lo), 64'(sv_lo));
    repeat (40) @(negedge clk);
    issue(2'b00, 32'd6, 32'hFFFF_FFFE);
    wait_idle();

    // Reset at iteration 20, then recover
    issue(DIV_EN ? 2'b11 : 2'b01, 32'd1000, 32'd3);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    void'(exp_q.pop_back());
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(2'b01, 32'd2, 32'd3);
    wait_idle();
    check("post_rst_lo", 64'(lo), 64'd6);

    repeat (40) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
